flop_pipe: RTL and testbench
============================

// Module: flop_pipe
//
// PURPOSE
//   Parametrised successor to the single-stage D flop: a WIDTH-bit, STAGES-deep
//   register pipeline (delay line).
//   - Per-stage valid tracking, global clock enable (stall), flush, occupancy count.
//   - Used to retime datapaths and to match latency between parallel paths.
//   - Every stage is an edge-triggered flop on clk.
//
// PARAMETERS
//   WIDTH      4    data width in bits (>=1)
//   STAGES     3    pipeline depth in flop stages (>=1)
//   RESET_VAL  '0   value loaded into every data stage on reset (WIDTH bits)
//
// PORTS
//   clk      in   1                     clock; all state updates on rising edge
//   reset    in   1                     synchronous, active-high reset
//   en       in   1                     advance pipeline one stage; 0 = hold all state
//   flush    in   1                     invalidate all in-flight entries
//   d        in   WIDTH                 data into stage 0
//   d_valid  in   1                     d carries a valid item
//   q        out  WIDTH                 data of last stage (stage STAGES-1)
//   q_valid  out  1                     valid bit of last stage
//   count    out  $clog2(STAGES+1)      number of stages currently holding valid items
//
// BEHAVIOUR
//   - State: data[0..STAGES-1] (WIDTH each), vld[0..STAGES-1], count register.
//     All state is registered, all outputs are direct flop outputs, and there is
//     no combinational path from any input to any output.
//   - Priority at each rising edge: reset > flush > en > hold.
//   - Reset (reset=1 at edge):
//       - data[i] <= RESET_VAL and vld[i] <= 0 for all i; count <= 0.
//       - After that edge q=RESET_VAL, q_valid=0, count=0.
//       - en, flush, d and d_valid are ignored.
//   - Shift (en=1, flush=0):
//       - data[0] <= d; vld[0] <= d_valid.
//       - data[i] <= data[i-1] and vld[i] <= vld[i-1] for i>=1.
//       - count <= count + d_valid - vld[STAGES-1] (item in minus item leaving).
//   - Hold (en=0, flush=0): all data, vld and count keep their values.
//     d and d_valid are dropped.
//   - Flush (flush=1, reset=0):
//       - vld[i] <= 0 for all i, including the incoming d_valid; count <= 0.
//       - Data registers still shift if en=1 and hold if en=0. Data is not cleared.
//   - Latency: an item presented with en=1 at edge k appears on q/q_valid after
//     edge k+STAGES-1. It is therefore visible on q during the cycle after the
//     STAGES-th enabled edge. Stalled cycles (en=0) add 1:1 to the latency.
//   - Boundaries:
//       - STAGES=1 degenerates to a single enabled flop plus valid bit;
//         count is 1 bit wide.
//       - Full (count=STAGES) streaming with d_valid=1: count stays STAGES,
//         with no overflow or wrap.
//       - Empty streaming with d_valid=0: count stays 0, with no underflow.
//       - Bubbles (d_valid=0) propagate as vld=0. The data field still shifts and is
//         don't-care to consumers, but it must not be X after reset.
//       - Reset mid-stream: all in-flight items are lost in one edge.
//       - flush together with en=0: valids clear and data holds.
//   - count invariant: count always equals popcount(vld). The bench checks this
//     every cycle.
//
// TESTING (WIDTH=4, STAGES=3, RESET_VAL=4'b0000)
//   1. reset=1 for 2 edges, d=4'b1111, d_valid=1, en=1
//      -> q=0000, q_valid=0, count=0 after each edge.
//   2. en=1: d=1111/v=1 at edge 1, d=1100/v=1 at edge 2, d_valid=0 after
//      -> q=1111/q_valid=1 after edge 3, q=1100 after edge 4, q_valid=0 after edge 5.
//      count sequence 1,2,2,1,0.
//   3. Start from state 2; drop en=0 for 5 edges mid-stream
//      -> q, q_valid, count are frozen. Resuming en=1 continues the sequence
//      exactly, delayed by 5 cycles.
//   4. Two items in flight (count=2), pulse flush=1 with en=1, d_valid=1
//      -> next edge count=0, q_valid=0; data registers still shifted (d appears in data[0]).
//   5. Fill to count=3, then reset=1 with en=1, d_valid=1
//      -> one edge later q=0000, q_valid=0, count=0; the incoming item is not captured.
//   6. Stream d_valid=1, en=1 for 10 edges with incrementing d
//      -> count saturates at 3 with no wrap. q equals d delayed by 3 edges.
//      The popcount(vld)==count invariant holds every cycle.

Source files
------------

// File: rtl/flop_pipe.sv
// -----------------------------------------------------------------------------
// flop_pipe
//
// Purpose:
//   WIDTH-bit, STAGES-deep register pipeline (delay line) with a valid bit per
//   stage, a global clock enable (stall), a flush that invalidates everything
//   in flight, and a registered occupancy count. Used to retime datapaths and
//   to match latency between parallel paths.
//
// Ports:
//   clk      in   1                  clock; all state updates on rising edge
//   reset    in   1                  synchronous, active-high reset
//   en       in   1                  advance pipeline one stage; 0 = hold
//   flush    in   1                  invalidate all in-flight entries
//   d        in   WIDTH              data into stage 0
//   d_valid  in   1                  d carries a valid item
//   q        out  WIDTH              data of the last stage
//   q_valid  out  1                  valid bit of the last stage
//   count    out  $clog2(STAGES+1)   number of stages holding valid items
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output. Priority at each edge: reset > flush > en > hold.
// -----------------------------------------------------------------------------
module flop_pipe #(
    parameter int                WIDTH     = 4,
    parameter int                STAGES    = 3,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          flush,
    input  logic [WIDTH-1:0]              d,
    input  logic                          d_valid,
    output logic [WIDTH-1:0]              q,
    output logic                          q_valid,
    output logic [$clog2(STAGES+1)-1:0]   count
);

    localparam int CW = $clog2(STAGES + 1);

    logic [WIDTH-1:0]  data [STAGES];
    logic [STAGES-1:0] vld;
    logic [CW-1:0]     count_r;

    // Data path. Flush deliberately does not touch the data registers: they
    // keep shifting (or holding) so bubbles carry defined, non-X contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                data[i] <= RESET_VAL;
            end
        end else if (en) begin
            data[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                data[i] <= data[i-1];
            end
        end
    end

    // Valid bits. Flush clears every stage, including the item arriving now.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld <= '0;
        end else if (en) begin
            vld[0] <= d_valid;
            for (int i = 1; i < STAGES; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // Occupancy: one item may enter and one may leave per shift, so the count
    // can never exceed STAGES nor drop below zero; modular arithmetic in CW
    // bits gives the exact result for every in/out combination.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + CW'(d_valid) - CW'(vld[STAGES-1]);
        end
    end

    assign q       = data[STAGES-1];
    assign q_valid = vld[STAGES-1];
    assign count   = count_r;

endmodule

// File: tb/tb_flop_pipe.sv
// -----------------------------------------------------------------------------
// tb_flop_pipe
//
// Self-checking bench for flop_pipe (WIDTH=4, STAGES=3, RESET_VAL=0).
// Valid items are pushed into a scoreboard queue when they enter the pipe and
// popped when the reference valid shift register says they reach the last
// stage. Valid and count are checked against that reference every cycle.
// -----------------------------------------------------------------------------
module tb_flop_pipe;

    localparam int WIDTH  = 4;
    localparam int STAGES = 3;
    localparam logic [WIDTH-1:0] RESET_VAL = 4'b0000;

    logic             clk;
    logic             reset;
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [1:0]       count;

    logic [WIDTH-1:0]  sb [$];
    logic [STAGES-1:0] mvld;
    logic [WIDTH-1:0]  prevQ;
    logic [WIDTH-1:0]  flushD;
    int                checks;
    int                failures;

    flop_pipe #(
        .WIDTH     (WIDTH),
        .STAGES    (STAGES),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .flush   (flush),
        .d       (d),
        .d_valid (d_valid),
        .q       (q),
        .q_valid (q_valid),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, advance one edge, update the reference and
    // check the outputs 1 time unit after the edge.
    task automatic applyStimulus(input logic r, input logic e, input logic f,
                                 input logic [WIDTH-1:0] dd, input logic dv);
        logic [WIDTH-1:0] exp;
        reset   = r;
        en      = e;
        flush   = f;
        d       = dd;
        d_valid = dv;
        @(posedge clk);
        #1;
        if (r) begin
            mvld = '0;
            sb.delete();
            checkOutput("reset_q", 32'(q), 32'(RESET_VAL));
        end else if (f) begin
            mvld = '0;
            sb.delete();
        end else if (e) begin
            if (dv) sb.push_back(dd);
            mvld = {mvld[STAGES-2:0], dv};
            if (mvld[STAGES-1]) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_underrun", 32'(0), 32'(1));
                end else begin
                    exp = sb.pop_front();
                    checkOutput("q_data", 32'(q), 32'(exp));
                end
            end
        end
        if (!r && !e) checkOutput("hold_q", 32'(q), 32'(prevQ));
        checkOutput("q_valid", 32'(q_valid), 32'(mvld[STAGES-1]));
        checkOutput("count", 32'(count), 32'($countones(mvld)));
        prevQ = q;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mvld     = '0;
        prevQ    = '0;
        flushD   = '0;

        // 1. Reset for two edges with active-looking inputs.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b1111, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b1111, 1'b1);

        // 2. Two items then bubbles; count runs 1,2,2,1,0.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111, 1'b1);
        checkOutput("t2_count1", 32'(count), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b1100, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        checkOutput("t2_q1111", 32'(q), 32'hF);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        checkOutput("t2_q1100", 32'(q), 32'hC);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        checkOutput("t2_empty", 32'(count), 32'd0);

        // 3. Same stream, stalled for 5 edges mid-flight.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b1100, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0101, 1'b1);
        checkOutput("t3_frozen_count", 32'(count), 32'd2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);

        // 4. Flush with en=1 while two items are in flight; the flushed d still
        //    travels through the data registers as a bubble.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0011, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0110, 1'b1);
        flushD = 4'b1010;
        applyStimulus(1'b0, 1'b1, 1'b1, flushD, 1'b1);
        checkOutput("t4_flush_count", 32'(count), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        checkOutput("t4_flush_data", 32'(q), 32'(flushD));

        // Flush with en=0: valids clear, data holds.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b1001, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0111, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        checkOutput("t4_hold_flush_data", 32'(q), 32'h9);

        // 5. Fill completely, then reset with a valid item presented.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0001, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0010, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0100, 1'b1);
        checkOutput("t5_full", 32'(count), 32'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b1000, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);

        // 6. Continuous streaming with incrementing data, then drain.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 4'(i + 3), 1'b1);
        checkOutput("t6_saturate", 32'(count), 32'd3);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);

        // Random mix of enables, bubbles and occasional flushes.
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 15) == 0),
                          4'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
